demodulator_psk_rx: RTL

- Receive-side counterpart of the PSK/PWM serializer. It samples the incoming serial bit line once per bit period and assembles PSK_BITS_PER_SYMBOL bits, LSB-first, into a byte.
- Each completed byte is pushed into a downstream FIFO through a write/full interface.
- Symbol framing comes from an external one-cycle sync pulse. After sync, the block receives back-to-back symbols until it is disabled or realigned.

---
 rtl/demodulator_psk_rx_if.sv | 38 +++
 rtl/demodulator_psk_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/demodulator_psk_rx_if.sv
// Bundle of control, serial-line and FIFO-write signals for the PSK receiver.
// The receiver is the master: it drives the write strobe and status flags
// and consumes enable, the serial line, the sync pulse and the FIFO full flag.
interface demodulator_psk_rx_if;
    logic       i_enable;
    logic       i_serial_in;
    logic       i_sync;
    logic       i_full;
    logic       o_write;
    logic [7:0] o_sample;
    logic       o_locked;
    logic       o_overflow;
    logic       o_symb_clk;

    modport master (
        input  i_enable,
        input  i_serial_in,
        input  i_sync,
        input  i_full,
        output o_write,
        output o_sample,
        output o_locked,
        output o_overflow,
        output o_symb_clk
    );

    modport slave (
        output i_enable,
        output i_serial_in,
        output i_sync,
        output i_full,
        input  o_write,
        input  o_sample,
        input  o_locked,
        input  o_overflow,
        input  o_symb_clk
    );
endinterface

// File: rtl/demodulator_psk_rx.sv
// PSK receiver: samples the serial line once per bit period, assembles
// PSK_BITS_PER_SYMBOL bits LSB-first into a symbol and pushes each completed
// symbol into a downstream FIFO. Framing comes from an external sync pulse;
// after that, symbols follow back-to-back until disabled or realigned.
module demodulator_psk_rx #(
    parameter int PSK_CLKS_PER_BIT    = 4,
    parameter int PSK_BITS_PER_SYMBOL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    demodulator_psk_rx_if.master bus
);

    localparam int CLK_W = (PSK_CLKS_PER_BIT > 2) ? $clog2(PSK_CLKS_PER_BIT) : 1;
    localparam int BIT_W = (PSK_BITS_PER_SYMBOL > 1) ? $clog2(PSK_BITS_PER_SYMBOL) : 1;

    localparam logic [CLK_W-1:0] CLK_LAST   = CLK_W'(PSK_CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_SAMPLE = CLK_W'(PSK_CLKS_PER_BIT / 2);
    localparam logic [CLK_W-1:0] CLK_ONE    = CLK_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(PSK_BITS_PER_SYMBOL - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_RUNNING
    } state_t;

    state_t                         r_state;

    logic                           r_sync_meta;
    logic                           r_sync_s;
    logic                           r_bit_meta;
    logic                           r_bit_s;

    logic [CLK_W-1:0]               r_cnt_clks;
    logic [BIT_W-1:0]               r_cnt_bits;
    logic [PSK_BITS_PER_SYMBOL-1:0] r_shift;

    logic                           r_write;
    logic [7:0]                     r_sample;
    logic                           r_locked;
    logic                           r_overflow;
    logic                           r_symb_clk;

    logic                           w_at_start;
    logic                           w_realign;
    logic                           w_clk_wrap;
    logic                           w_sym_end;
    logic                           w_sample_pt;
    logic [CLK_W-1:0]               w_clks_next;
    logic [BIT_W-1:0]               w_bits_next;
    logic [PSK_BITS_PER_SYMBOL-1:0] w_assembled;
    logic [7:0]                     w_symbol;

    // Two identical synchronizer chains keep sync and data aligned with each other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_meta <= 1'b0;
            r_sync_s    <= 1'b0;
            r_bit_meta  <= 1'b0;
            r_bit_s     <= 1'b0;
        end else begin
            r_sync_meta <= bus.i_sync;
            r_sync_s    <= r_sync_meta;
            r_bit_meta  <= bus.i_serial_in;
            r_bit_s     <= r_bit_meta;
        end
    end

    // Decode counter position: realignment, sample point, symbol end and next counts.
    always_comb begin
        w_at_start  = (r_cnt_clks == '0) && (r_cnt_bits == '0);
        w_realign   = r_sync_s && !w_at_start;
        w_clk_wrap  = (r_cnt_clks == CLK_LAST);
        w_sym_end   = w_clk_wrap && (r_cnt_bits == BIT_LAST) && !w_realign;
        w_sample_pt = (r_cnt_clks == CLK_SAMPLE) && !w_realign;

        w_clks_next = w_clk_wrap ? '0 : r_cnt_clks + CLK_ONE;
        w_bits_next = r_cnt_bits;
        if (w_clk_wrap) begin
            w_bits_next = (r_cnt_bits == BIT_LAST) ? '0 : r_cnt_bits + BIT_ONE;
        end
    end

    // Symbol as it stands after this clock, including a bit sampled in the same cycle.
    always_comb begin
        w_assembled = r_shift;
        if (w_sample_pt) begin
            w_assembled[r_cnt_bits] = r_bit_s;
        end
        w_symbol = '0;
        w_symbol[PSK_BITS_PER_SYMBOL-1:0] = w_assembled;
    end

    // Framing FSM with counters, bit capture and registered FIFO-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt_clks <= '0;
            r_cnt_bits <= '0;
            r_shift    <= '0;
            r_write    <= 1'b0;
            r_sample   <= '0;
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
            r_symb_clk <= 1'b0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt_clks <= '0;
                    r_cnt_bits <= '0;
                    if (bus.i_enable && r_sync_s) begin
                        r_state    <= ST_RUNNING;
                        r_locked   <= 1'b1;
                        r_cnt_clks <= CLK_ONE;
                        r_shift    <= '0;
                    end
                end

                ST_RUNNING: begin
                    if (w_sym_end) begin
                        r_sample <= w_symbol;
                        if (!bus.i_full) begin
                            r_write    <= 1'b1;
                            r_symb_clk <= ~r_symb_clk;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end

                    if (!bus.i_enable) begin
                        r_state    <= ST_IDLE;
                        r_locked   <= 1'b0;
                        r_cnt_clks <= '0;
                        r_cnt_bits <= '0;
                    end else if (w_realign) begin
                        r_cnt_clks <= CLK_ONE;
                        r_cnt_bits <= '0;
                        r_shift    <= '0;
                    end else begin
                        r_cnt_clks <= w_clks_next;
                        r_cnt_bits <= w_bits_next;
                        r_shift    <= w_assembled;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_write    = r_write;
    assign bus.o_sample   = r_sample;
    assign bus.o_locked   = r_locked;
    assign bus.o_overflow = r_overflow;
    assign bus.o_symb_clk = r_symb_clk;

endmodule
